fir2d_5x5_core: RTL and testbench

- Pipelined 5x5 2D FIR datapath. It sits directly downstream of the coefficient loader.
- Takes one 5-pixel column per active cycle and keeps a 5x5 sliding window. It convolves the window with 25 signed coefficients and emits one rounded, clamped 8-bit pixel per cycle.
- Video timing (hs/vs/de) is delayed to match the output.
- Coefficients are double-buffered, so a load in progress never corrupts filtering.

---
 rtl/fir2d_pkg.sv | 33 +++
 rtl/fir2d_5x5_core_if.sv | 27 ++
 rtl/fir2d_row_mac.sv | 38 +++
 rtl/fir2d_5x5_core.sv | 81 ++++++++
 tb/tb_fir2d_5x5_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir2d_pkg.sv
// Shared constants, types and the output rounding helper for the 5x5 FIR core.
// LATENCY is exported so neighbouring stages can align their own timing.
package fir2d_pkg;

  localparam int PIX_W      = 8;
  localparam int COEFF_W    = 16;
  localparam int COEFF_FRAC = 8;
  localparam int KERNEL     = 5;
  localparam int NTAPS      = KERNEL * KERNEL;
  localparam int ACC_W      = PIX_W + 1 + COEFF_W + 5;
  localparam int PROD_W     = PIX_W + 1 + COEFF_W;
  localparam int ROW_W      = PROD_W + 3;
  localparam int LATENCY    = 5;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  // Round half up at COEFF_FRAC, then saturate to the unsigned pixel range.
  function automatic pix_t round_clamp(acc_t acc);
    acc_t rnd;
    acc_t sh;
    rnd = acc + acc_t'(1 << (COEFF_FRAC - 1));
    sh  = rnd >>> COEFF_FRAC;
    if (sh < 0)
      return '0;
    else if (sh > acc_t'((1 << PIX_W) - 1))
      return '1;
    else
      return sh[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/fir2d_5x5_core_if.sv
// Video column in / filtered pixel out bundle for fir2d_5x5_core, with the
// coefficient loader signals that travel alongside it.
interface fir2d_5x5_core_if;
  import fir2d_pkg::*;

  logic [KERNEL*PIX_W-1:0]  col_i;
  logic                     de_i;
  logic                     hs_i;
  logic                     vs_i;
  logic [NTAPS*COEFF_W-1:0] coeff_flat_i;
  logic                     coeff_busy_i;
  pix_t                     pix_o;
  logic                     de_o;
  logic                     hs_o;
  logic                     vs_o;

  modport master (
    output col_i, de_i, hs_i, vs_i, coeff_flat_i, coeff_busy_i,
    input  pix_o, de_o, hs_o, vs_o
  );

  modport slave (
    input  col_i, de_i, hs_i, vs_i, coeff_flat_i, coeff_busy_i,
    output pix_o, de_o, hs_o, vs_o
  );

endinterface

// File: rtl/fir2d_row_mac.sv
// One kernel row: five pixel x coefficient products (registered), then their
// signed sum (registered).
module fir2d_row_mac
  import fir2d_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KERNEL-1:0][PIX_W-1:0]   pix,
  input  logic [KERNEL-1:0][COEFF_W-1:0] coeff,
  output logic [ROW_W-1:0]               row_sum
);

  logic [KERNEL-1:0][PROD_W-1:0] prod_d, prod_q;
  logic [ROW_W-1:0]              sum_d;

  // Both operands widened to the product width so the low bits are exact.
  for (genvar c = 0; c < KERNEL; c++) begin : g_tap
    assign prod_d[c] = {{(PROD_W-PIX_W){1'b0}}, pix[c]} *
                       {{(PROD_W-COEFF_W){coeff[c][COEFF_W-1]}}, coeff[c]};
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < KERNEL; c++)
      sum_d = sum_d + {{(ROW_W-PROD_W){prod_q[c][PROD_W-1]}}, prod_q[c]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q  <= '0;
      row_sum <= '0;
    end else begin
      prod_q  <= prod_d;
      row_sum <= sum_d;
    end
  end

endmodule

// File: rtl/fir2d_5x5_core.sv
// Pipelined 5x5 2D FIR: sliding window, five row MACs, total, round/clamp.
// Coefficients are shadowed and only swapped when the loader drops busy.
module fir2d_5x5_core
  import fir2d_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fir2d_5x5_core_if.slave bus
);

  logic [KERNEL-1:0][KERNEL-1:0][PIX_W-1:0] win;      // [row][col], col 4 newest
  logic [NTAPS-1:0][COEFF_W-1:0]            coeff_act;
  logic                                     busy_dly;
  logic [LATENCY:0]                         de_pipe, hs_pipe, vs_pipe;
  logic [KERNEL-1:0][ROW_W-1:0]             row_sum;
  acc_t                                     acc_d, acc_q;
  pix_t                                     pix_q;
  logic                                     line_end;

  assign de_pipe[0] = bus.de_i;
  assign hs_pipe[0] = bus.hs_i;
  assign vs_pipe[0] = bus.vs_i;
  assign line_end   = de_pipe[1] & ~bus.de_i;

  // Window and coefficient shadow; clearing at line end zero-pads the left border.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win       <= '0;
      coeff_act <= '0;
      busy_dly  <= 1'b0;
    end else begin
      busy_dly <= bus.coeff_busy_i;
      if (busy_dly && !bus.coeff_busy_i)
        coeff_act <= bus.coeff_flat_i;
      if (bus.de_i) begin
        for (int r = 0; r < KERNEL; r++)
          win[r] <= {bus.col_i[r*PIX_W +: PIX_W], win[r][KERNEL-1:1]};
      end else if (line_end) begin
        win <= '0;
      end
    end
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    fir2d_row_mac u_row (
      .clk     (clk),
      .rst     (rst),
      .pix     (win[r]),
      .coeff   (coeff_act[r*KERNEL +: KERNEL]),
      .row_sum (row_sum[r])
    );
  end

  always_comb begin
    acc_d = '0;
    for (int r = 0; r < KERNEL; r++)
      acc_d = acc_d + {{(ACC_W-ROW_W){row_sum[r][ROW_W-1]}}, row_sum[r]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q              <= '0;
      pix_q              <= '0;
      de_pipe[LATENCY:1] <= '0;
      hs_pipe[LATENCY:1] <= '0;
      vs_pipe[LATENCY:1] <= '0;
    end else begin
      acc_q              <= acc_d;
      pix_q              <= round_clamp(acc_q);
      de_pipe[LATENCY:1] <= de_pipe[LATENCY-1:0];
      hs_pipe[LATENCY:1] <= hs_pipe[LATENCY-1:0];
      vs_pipe[LATENCY:1] <= vs_pipe[LATENCY-1:0];
    end
  end

  assign bus.pix_o = pix_q;
  assign bus.de_o  = de_pipe[LATENCY];
  assign bus.hs_o  = hs_pipe[LATENCY];
  assign bus.vs_o  = vs_pipe[LATENCY];

endmodule

// File: tb/tb_fir2d_5x5_core.sv
// Randomized bench for fir2d_5x5_core against a convolution-level reference
// model, plus known-answer sequences for identity, rounding, saturation,
// shadow and line-end behaviour.
module tb_fir2d_5x5_core;
  import fir2d_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir2d_5x5_core_if bus();

  fir2d_5x5_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame window, active kernel, expected-output queue.
  typedef struct {int pix; bit de; bit hs; bit vs;} exp_t;
  int   m_win[KERNEL][KERNEL];
  int   m_coef[NTAPS];
  bit   m_busy_dly, m_de_dly;
  exp_t expq[$];
  int   kat[$];

  task automatic model_reset();
    exp_t z;
    z = '{pix: 0, de: 1'b0, hs: 1'b0, vs: 1'b0};
    foreach (m_win[r, c]) m_win[r][c] = 0;
    foreach (m_coef[k]) m_coef[k] = 0;
    m_busy_dly = 1'b0;
    m_de_dly   = 1'b0;
    expq.delete();
    repeat (LATENCY - 1) expq.push_back(z);
  endtask

  task automatic model_edge();
    exp_t e;
    int   sum, q;
    if (m_busy_dly && !bus.coeff_busy_i)
      for (int k = 0; k < NTAPS; k++)
        m_coef[k] = int'($signed(bus.coeff_flat_i[k*COEFF_W +: COEFF_W]));
    m_busy_dly = bus.coeff_busy_i;
    if (bus.de_i) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) m_win[r][c] = m_win[r][c+1];
        m_win[r][KERNEL-1] = int'(bus.col_i[r*PIX_W +: PIX_W]);
      end
    end else if (m_de_dly) begin
      foreach (m_win[r, c]) m_win[r][c] = 0;
    end
    m_de_dly = bus.de_i;
    sum = 0;
    for (int r = 0; r < KERNEL; r++)
      for (int c = 0; c < KERNEL; c++)
        sum += m_win[r][c] * m_coef[r*KERNEL + c];
    q = (sum + 128) >>> 8;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    e = '{pix: q, de: bus.de_i, hs: bus.hs_i, vs: bus.vs_i};
    expq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = expq.pop_front();
    chk("sync", int'({bus.de_o, bus.hs_o, bus.vs_o}), int'({e.de, e.hs, e.vs}));
    if (e.de) begin
      chk("pix", int'(bus.pix_o), e.pix);
      if (kat.size() > 0) chk("kat", int'(bus.pix_o), kat.pop_front());
    end
  endtask

  function automatic logic [KERNEL*PIX_W-1:0] rcol();
    logic [KERNEL*PIX_W-1:0] v;
    v[31:0]  = $urandom();
    v[39:32] = 8'($urandom());
    return v;
  endfunction

  task automatic cyc(input bit de, input logic [KERNEL*PIX_W-1:0] col);
    bus.de_i  = de;
    bus.hs_i  = 1'($urandom_range(0, 1));
    bus.vs_i  = 1'($urandom_range(0, 1));
    bus.col_i = col;
    step();
  endtask

  task automatic gap(input int n);
    repeat (n) cyc(1'b0, rcol());
  endtask

  // Busy pulse then fall; afterwards the flat bus carries junk that must be ignored.
  task automatic load(input logic [NTAPS*COEFF_W-1:0] flat);
    bus.coeff_flat_i = flat;
    bus.coeff_busy_i = 1'b1;
    cyc(1'b0, rcol());
    bus.coeff_busy_i = 1'b0;
    cyc(1'b0, rcol());
    bus.coeff_flat_i = {13{$urandom()}};
    cyc(1'b0, rcol());
  endtask

  function automatic logic [NTAPS*COEFF_W-1:0] one_tap(input int k, input int v);
    logic [NTAPS*COEFF_W-1:0] f;
    f = '0;
    f[k*COEFF_W +: COEFF_W] = 16'(v);
    return f;
  endfunction

  function automatic logic [NTAPS*COEFF_W-1:0] all_taps(input int v);
    logic [NTAPS*COEFF_W-1:0] f;
    for (int k = 0; k < NTAPS; k++) f[k*COEFF_W +: COEFF_W] = 16'(v);
    return f;
  endfunction

  function automatic logic [KERNEL*PIX_W-1:0] row2(input int v);
    logic [KERNEL*PIX_W-1:0] col;
    col = rcol();
    col[2*PIX_W +: PIX_W] = 8'(v);
    return col;
  endfunction

  initial begin
    logic [NTAPS*COEFF_W-1:0] flat;
    bus.col_i = '0; bus.de_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
    bus.coeff_flat_i = '0; bus.coeff_busy_i = 1'b0;
    model_reset();

    repeat (2) begin
      @(negedge clk);
      chk("rst_pix", int'(bus.pix_o), 0);
      chk("rst_sync", int'({bus.de_o, bus.hs_o, bus.vs_o}), 0);
    end
    rst = 1'b1;

    // Identity kernel on a row-2 ramp: output n is ramp n-2 (zero-padded).
    load(one_tap(12, 256));
    for (int n = 0; n < 20; n++) kat.push_back(n < 2 ? 0 : n - 2);
    for (int n = 0; n < 20; n++) cyc(1'b1, row2(n));
    gap(10);
    chk("kat_identity_done", kat.size(), 0);

    // Half-weight centre tap: 1.5 -> 2, 2.0 -> 2, 2.5 -> 3.
    load(one_tap(12, 128));
    kat = '{0, 0, 2, 2, 3};
    cyc(1'b1, row2(3)); cyc(1'b1, row2(4)); cyc(1'b1, row2(5));
    cyc(1'b1, row2(0)); cyc(1'b1, row2(0));
    gap(8);
    chk("kat_round_done", kat.size(), 0);

    // Saturation high then low.
    load(all_taps(256));
    repeat (6) kat.push_back(255);
    repeat (6) cyc(1'b1, {KERNEL{8'd200}});
    gap(8);
    load(one_tap(12, -256));
    repeat (6) kat.push_back(0);
    repeat (6) cyc(1'b1, {KERNEL{8'd200}});
    gap(8);
    chk("kat_sat_done", kat.size(), 0);

    // Shadow: zero kernel on the bus while busy must not disturb filtering.
    load(one_tap(12, 256));
    bus.coeff_busy_i = 1'b1;
    bus.coeff_flat_i = '0;
    repeat (25) cyc(1'b1, rcol());
    bus.coeff_busy_i = 1'b0;
    repeat (6) cyc(1'b1, rcol());
    repeat (5) kat.push_back(0);
    repeat (5) cyc(1'b1, rcol());
    gap(8);
    chk("kat_shadow_done", kat.size(), 0);

    // Line end clears the window: box kernel of 10 over all-255 pixels.
    load(all_taps(10));
    repeat (8) cyc(1'b1, {KERNEL{8'd255}});
    gap(10);
    kat = '{50, 100, 149, 199, 249};
    repeat (8) cyc(1'b1, {KERNEL{8'd255}});
    gap(8);
    chk("kat_lineend_done", kat.size(), 0);

    // Random kernel, data enable and loader activity.
    for (int k = 0; k < NTAPS; k++) flat[k*COEFF_W +: COEFF_W] = 16'($urandom());
    load(flat);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) bus.coeff_busy_i = ~bus.coeff_busy_i;
      if (bus.coeff_busy_i)
        for (int k = 0; k < NTAPS; k++)
          bus.coeff_flat_i[k*COEFF_W +: COEFF_W] = 16'($urandom_range(0, 1023) - 512);
      cyc(1'($urandom_range(0, 9) < 7), rcol());
    end
    bus.coeff_busy_i = 1'b0;
    gap(8);

    // Asynchronous reset mid-line clears outputs and the active kernel.
    load(one_tap(12, 256));
    repeat (6) cyc(1'b1, rcol());
    #2 rst = 1'b0;
    #1;
    chk("arst_pix", int'(bus.pix_o), 0);
    chk("arst_sync", int'({bus.de_o, bus.hs_o, bus.vs_o}), 0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("arst_hold_pix", int'(bus.pix_o), 0);
      chk("arst_hold_de", int'(bus.de_o), 0);
    end
    rst = 1'b1;
    repeat (10) kat.push_back(0);
    repeat (10) cyc(1'b1, rcol());
    gap(8);
    chk("kat_arst_done", kat.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
